shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit logical right shifter (`rightShifter`, 3-bit amount) among `NREQ` requesters. Each requester submits an operand and a shift amount over a valid/ready handshake. The block grants one requester at a time, registers the operand, drives the shifter and returns the registered result with the requester ID over a response handshake that honours backpressure. It sits between the client-side shift request ports and the single shifter datapath instance.

---
 rtl/shift_arb_pkg.sv | 21 ++
 rtl/rightShifter.sv | 24 ++
 rtl/shift_arbiter_rr_picker.sv | 45 ++++
 rtl/shift_arbiter.sv | 141 ++++++++++++++
 tb/tb_shift_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_arb_pkg.sv
// -----------------------------------------------------------------------------
// shift_arb_pkg
// Shared types and widths for the shift_arbiter block.
//   state_t : arbiter/sequencer FSM states (IDLE, SHIFT, RESP)
//   DATA_W  : operand/result width of the shared shifter
//   AMT_W   : shift amount width
//   STAT_W  : width of the optional per-requester grant counters
// -----------------------------------------------------------------------------
package shift_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
  localparam int STAT_W = 16;

endpackage

// File: rtl/rightShifter.sv
// -----------------------------------------------------------------------------
// rightShifter
// Existing 8-bit logical right shifter, zero fill, three binary-weighted stages.
// Ports:
//   a          in  8 : operand
//   s2, s1, s0 in  1 : shift amount bits (weights 4, 2, 1)
//   y          out 8 : a >> {s2,s1,s0}
// -----------------------------------------------------------------------------
module rightShifter (
  input  logic [7:0] a,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  output logic [7:0] y
);

  logic [7:0] st1;
  logic [7:0] st2;

  assign st1 = s0 ? {1'b0, a[7:1]}     : a;
  assign st2 = s1 ? {2'b00, st1[7:2]}  : st1;
  assign y   = s2 ? {4'h0, st2[7:4]}   : st2;

endmodule

// File: rtl/shift_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Searches req starting at ptr and wrapping
// modulo NREQ; the first set bit wins.
// Ports:
//   req   in  NREQ : request vector
//   ptr   in  IDW  : search start index
//   grant out NREQ : one-hot winner (all zero when no request)
//   idx   out IDW  : encoded winner index (0 when no request)
//   any   out 1    : at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // One spare bit so ptr + offset never overflows before the modulo fold.
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Round-robin arbiter/sequencer sharing one rightShifter among NREQ requesters.
// Accept in IDLE -> operand shifted in SHIFT -> result held in RESP until taken.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_valid   in  NREQ      : per-requester valid
//   req_ready   out NREQ      : one-hot accept (only in IDLE)
//   req_data    in  NREQ*8    : operands, requester i at [8*i +: 8]
//   req_amt     in  NREQ*3    : shift amounts, requester i at [3*i +: 3]
//   rsp_valid   out 1         : result available
//   rsp_ready   in  1         : consumer accepts result
//   rsp_data    out 8         : shifted result
//   rsp_id      out IDW       : owner of rsp_data
//   busy        out 1         : FSM not in IDLE
// Optional feature macro SHIFT_ARB_STATS_EN adds:
//   stat_sel    in  IDW       : counter select
//   stat_count  out 16        : saturating grant count of the selected requester
// -----------------------------------------------------------------------------
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  input  logic [NREQ*AMT_W-1:0]   req_amt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy
`ifdef SHIFT_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]          stat_sel,
  output logic [STAT_W-1:0]       stat_count
`endif
);

  state_t state, state_nx;

  logic [IDW-1:0]    ptr;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    win_idx;
  logic              win_any;
  logic              accept;

  logic [DATA_W-1:0] op_data_p0;
  logic [AMT_W-1:0]  op_amt_p0;
  logic [IDW-1:0]    op_id_p0;
  logic [DATA_W-1:0] shift_out;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] idx);
    if (idx == IDW'(NREQ-1)) return '0;
    return idx + 1'b1;
  endfunction

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign accept    = (state == IDLE) && win_any;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_any)   state_nx = SHIFT;
      SHIFT:                  state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Stage p0: capture the winner's operand, amount and ID; advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_data_p0 <= '0;
      op_amt_p0  <= '0;
      op_id_p0   <= '0;
      ptr        <= '0;
    end else if (accept) begin
      op_data_p0 <= req_data[DATA_W*win_idx +: DATA_W];
      op_amt_p0  <= req_amt[AMT_W*win_idx +: AMT_W];
      op_id_p0   <= win_idx;
      ptr        <= ptr_after(win_idx);
    end
  end

  rightShifter u_shift (
    .a  (op_data_p0),
    .s2 (op_amt_p0[2]),
    .s1 (op_amt_p0[1]),
    .s0 (op_amt_p0[0]),
    .y  (shift_out)
  );

  // Response stage: registered shifter result, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (state == SHIFT) begin
      rsp_valid <= 1'b1;
      rsp_data  <= shift_out;
      rsp_id    <= op_id_p0;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (accept && (grant_cnt[win_idx] != '1)) begin
      grant_cnt[win_idx] <= grant_cnt[win_idx] + 1'b1;
    end
  end

  assign stat_count = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Directed bench for shift_arbiter (NREQ=4). Stats checks are compiled only
// when SHIFT_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  localparam int NREQ = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef SHIFT_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_count;
`endif

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_count(stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs must already be driven; rsp_ready must be 1.
  task automatic run_op(input string tag, input int exp_id, input logic [7:0] exp_data);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << exp_id));
    tick();
    check({tag, "_shift_busy"}, 32'(busy), 32'd1);
    check({tag, "_shift_rdy0"}, 32'(req_ready), 32'd0);
    check({tag, "_shift_rv0"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_rv"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_rv_clr"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b1;
`ifdef SHIFT_ARB_STATS_EN
    stat_sel  = '0;
`endif

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: all valid, 8'h80 >> 1 = 8'h40, grants 0,1,2,3,0
    req_valid = 4'b1111;
    req_data  = {4{8'h80}};
    req_amt   = {4{3'd1}};
    run_op("rr0", 0, 8'h40);
    run_op("rr1", 1, 8'h40);
    run_op("rr2", 2, 8'h40);
    run_op("rr3", 3, 8'h40);
    run_op("rr4", 0, 8'h40);
    req_valid = '0;

    // Single request: requester 2, 8'hB4 >> 3 = 8'h16; ptr moves to 3
    req_valid = 4'b0100;
    req_data  = 32'h00B4_0000;
    req_amt   = 12'(3 << 6);
    run_op("single", 2, 8'h16);
    req_valid = '0;

    // ptr=3 shows up as the next winner with everyone requesting
    req_valid = 4'b1111;
    req_data  = {4{8'h01}};
    req_amt   = '0;
    run_op("ptr3", 3, 8'h01);
    req_valid = '0;

    // Boundary amounts
    req_valid = 4'b0001;
    req_data  = 32'h0000_00FF;
    req_amt   = 12'd0;
    run_op("amt0", 0, 8'hFF);
    req_valid = 4'b0010;
    req_data  = 32'h0000_FF00;
    req_amt   = 12'(7 << 3);
    run_op("amt7_ff", 1, 8'h01);
    req_valid = 4'b1000;
    req_data  = 32'h7F00_0000;
    req_amt   = 12'(7 << 9);
    run_op("amt7_7f", 3, 8'h00);
    req_valid = '0;

    // Backpressure: requester 1, 8'h5A >> 2 = 8'h16, held for 10 cycles
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_data  = 32'h0000_5A00;
    req_amt   = 12'(2 << 3);
    #1;
    check("bp_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_rv", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h16);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_rdy0", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_rv_clr", 32'(rsp_valid), 32'd0);

    // Reset in SHIFT: ptr is 2 here, so requester 2 is in flight
    req_valid = 4'b1111;
    req_data  = {4{8'h80}};
    req_amt   = {4{3'd1}};
    #1;
    check("rs_ready", 32'(req_ready), 32'b0100);
    tick();
    check("rs_in_shift", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_rv", 32'(rsp_valid), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rs_no_rsp", 32'(rsp_valid), 32'd0);
    run_op("rs_first", 0, 8'h40);
    req_valid = '0;

`ifdef SHIFT_ARB_STATS_EN
    // Counters were cleared by the reset above; requester 0 has one grant since.
    req_valid = 4'b0010;
    req_data  = 32'h0000_1000;
    req_amt   = 12'(1 << 3);
    run_op("st_a", 1, 8'h08);
    run_op("st_b", 1, 8'h08);
    run_op("st_c", 1, 8'h08);
    req_valid = '0;
    stat_sel  = 2'd1;
    #1;
    check("stat_cnt3", 32'(stat_count), 32'd3);
    force dut.grant_cnt[1] = 16'hFFFF;
    #1;
    release dut.grant_cnt[1];
    req_valid = 4'b0010;
    run_op("st_sat", 1, 8'h08);
    req_valid = '0;
    #1;
    check("stat_sat", 32'(stat_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
